// File: rtl/activation_index_sequencer.sv
// Avalon-MM controlled sequencer that walks the activation index from FIRST to LAST,
// pulsing act_start per index and waiting on act_done with an optional per-step timeout.
module activation_index_sequencer #(
  parameter int INDEX_W   = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq,
  output logic [INDEX_W-1:0]   act_index,
  output logic                 act_start,
  input  logic                 act_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_irqEn;
  logic                   r_manual;
  logic [INDEX_W-1:0]     r_first;
  logic [INDEX_W-1:0]     r_last;
  logic [INDEX_W-1:0]     r_idx;
  logic [TIMEOUT_W-1:0]   r_timeout;
  logic [TIMEOUT_W-1:0]   r_timer;
  logic                   r_done;
  logic                   r_tmo;
  logic                   r_rangeErr;
  logic                   r_actStart;

  logic                   w_write;
  logic                   w_ctrlWr;
  logic                   w_rangeWr;
  logic                   w_statusWr;
  logic                   w_timeoutWr;
  logic                   w_start;
  logic                   w_abort;
  logic                   w_busy;
  logic                   w_timeoutHit;
  logic                   w_unused;

  assign w_write     = chipselect & ~write_n;
  assign w_ctrlWr    = w_write & (address == 2'd0);
  assign w_rangeWr   = w_write & (address == 2'd1);
  assign w_statusWr  = w_write & (address == 2'd2);
  assign w_timeoutWr = w_write & (address == 2'd3);
  assign w_start     = w_ctrlWr & writedata[0];
  assign w_abort     = w_ctrlWr & writedata[1];
  assign w_busy      = (r_state != S_IDLE);
  assign w_timeoutHit = (r_timeout != '0) && (r_timer == (r_timeout - TIMEOUT_W'(1)));
  assign w_unused    = ^writedata;

  assign act_start = r_actStart;
  assign act_index = r_manual ? r_first : r_idx;
  assign irq       = r_irqEn & (r_done | r_tmo | r_rangeErr);

  // Sticky-bit clears come before the FSM so a same-cycle set event overrides the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_irqEn    <= 1'b0;
      r_manual   <= 1'b0;
      r_first    <= '0;
      r_last     <= '0;
      r_idx      <= '0;
      r_timeout  <= '0;
      r_timer    <= '0;
      r_done     <= 1'b0;
      r_tmo      <= 1'b0;
      r_rangeErr <= 1'b0;
      r_actStart <= 1'b0;
    end else begin
      r_actStart <= 1'b0;
      if (w_ctrlWr) begin
        r_irqEn  <= writedata[2];
        r_manual <= writedata[3];
      end
      if (w_rangeWr && !w_busy) begin
        r_first <= writedata[INDEX_W-1:0];
        r_last  <= writedata[16+INDEX_W-1:16];
      end
      if (w_timeoutWr) begin
        r_timeout <= writedata[TIMEOUT_W-1:0];
      end
      if (w_statusWr) begin
        if (writedata[1]) r_done     <= 1'b0;
        if (writedata[2]) r_tmo      <= 1'b0;
        if (writedata[3]) r_rangeErr <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start && !w_abort && !r_manual) begin
            if (r_first <= r_last) begin
              r_idx      <= r_first;
              r_actStart <= 1'b1;
              r_state    <= S_ISSUE;
            end else begin
              r_rangeErr <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= w_abort ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (r_timer != '1) r_timer <= r_timer + TIMEOUT_W'(1);
          // act_done takes priority over a timeout landing on the same cycle.
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (act_done) begin
            if (r_idx == r_last) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx      <= r_idx + INDEX_W'(1);
              r_actStart <= 1'b1;
              r_state    <= S_ISSUE;
            end
          end else if (w_timeoutHit) begin
            r_tmo   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[2] = r_irqEn;
        readdata[3] = r_manual;
      end
      2'd1: begin
        readdata[INDEX_W-1:0]     = r_first;
        readdata[16+INDEX_W-1:16] = r_last;
      end
      2'd2: begin
        readdata[0]               = w_busy;
        readdata[1]               = r_done;
        readdata[2]               = r_tmo;
        readdata[3]               = r_rangeErr;
        readdata[8+INDEX_W-1:8]   = r_idx;
      end
      2'd3: begin
        readdata[TIMEOUT_W-1:0] = r_timeout;
      end
    endcase
  end

endmodule

// File: tb/tb_activation_index_sequencer.sv
// Directed self-checking bench for activation_index_sequencer with a simple
// act_done responder and an act_start pulse monitor.
module tb_activation_index_sequencer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  act_index;
  logic        act_start;
  logic        act_done;

  logic        respEn;
  logic        respDone;
  logic        tbDone;
  int          respDelay;
  int          respCnt;
  int          pulseCount;
  logic [3:0]  idxLog [64];
  int          testsRun;
  int          failCount;

  assign act_done = respDone | tbDone;

  activation_index_sequencer #(.INDEX_W(4), .TIMEOUT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .act_index  (act_index),
    .act_start  (act_start),
    .act_done   (act_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns act_done respDelay cycles after each observed act_start.
  always @(negedge clk) begin
    if (respDone) respDone = 1'b0;
    if (respEn && act_start) begin
      respCnt = respDelay;
    end else if (respCnt > 0) begin
      respCnt = respCnt - 1;
      if (respCnt == 0) respDone = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (act_start) begin
      if (pulseCount < 64) idxLog[pulseCount] = act_index;
      pulseCount = pulseCount + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] value);
    address = addr;
    #1;
    value = readdata;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle(input string tag);
    logic [31:0] st;
    st = 32'h1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      readReg(2'd2, st);
      if (st[0] == 1'b0) break;
    end
    checkOutput(tag, {31'b0, st[0]}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int base;
    logic found;

    testsRun   = 0;
    failCount  = 0;
    pulseCount = 0;
    respEn     = 1'b0;
    respDone   = 1'b0;
    tbDone     = 1'b0;
    respDelay  = 3;
    respCnt    = 0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    reset_n    = 1'b0;

    // Reset state
    waitCycles(3);
    readReg(2'd0, rd); checkOutput("reset_ctrl", rd, 32'h0);
    readReg(2'd1, rd); checkOutput("reset_range", rd, 32'h0);
    readReg(2'd2, rd); checkOutput("reset_status", rd, 32'h0);
    readReg(2'd3, rd); checkOutput("reset_timeout", rd, 32'h0);
    checkOutput("reset_outs", {29'b0, act_start, irq, |act_index}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Nominal sequence 2..5 with 3-cycle responder
    applyStimulus(2'd1, 32'h0005_0002);
    applyStimulus(2'd3, 32'h0);
    respDelay = 3;
    respEn    = 1'b1;
    base      = pulseCount;
    applyStimulus(2'd0, 32'h5);
    checkOutput("nom_first_start", {31'b0, act_start}, 32'h1);
    checkOutput("nom_first_index", {28'b0, act_index}, 32'h2);
    waitIdle("nom_idle");
    checkOutput("nom_pulses", pulseCount - base, 32'd4);
    checkOutput("nom_idx0", {28'b0, idxLog[base]}, 32'h2);
    checkOutput("nom_idx1", {28'b0, idxLog[base+1]}, 32'h3);
    checkOutput("nom_idx2", {28'b0, idxLog[base+2]}, 32'h4);
    checkOutput("nom_idx3", {28'b0, idxLog[base+3]}, 32'h5);
    readReg(2'd2, rd); checkOutput("nom_status", rd, 32'h502);
    checkOutput("nom_irq", {31'b0, irq}, 32'h1);
    applyStimulus(2'd2, 32'h2);
    checkOutput("nom_irq_clr", {31'b0, irq}, 32'h0);
    readReg(2'd2, rd); checkOutput("nom_status_clr", rd, 32'h500);

    // Timeout of 10 cycles with silent responder
    respEn = 1'b0;
    applyStimulus(2'd1, 32'h0007_0001);
    applyStimulus(2'd3, 32'd10);
    base = pulseCount;
    applyStimulus(2'd0, 32'h1);
    checkOutput("tmo_start", {31'b0, act_start}, 32'h1);
    waitCycles(10);
    readReg(2'd2, rd); checkOutput("tmo_before", rd, 32'h101);
    @(negedge clk);
    readReg(2'd2, rd); checkOutput("tmo_set", rd, 32'h104);
    checkOutput("tmo_irq_disabled", {31'b0, irq}, 32'h0);
    checkOutput("tmo_pulses", pulseCount - base, 32'd1);
    applyStimulus(2'd2, 32'h4);

    // FIRST == LAST == 15
    applyStimulus(2'd3, 32'h0);
    applyStimulus(2'd1, 32'h000F_000F);
    respEn = 1'b1;
    base   = pulseCount;
    applyStimulus(2'd0, 32'h1);
    waitIdle("one_idle");
    checkOutput("one_pulses", pulseCount - base, 32'd1);
    checkOutput("one_idx", {28'b0, idxLog[base]}, 32'hF);
    readReg(2'd2, rd); checkOutput("one_status", rd, 32'hF02);
    applyStimulus(2'd2, 32'h2);

    // FIRST > LAST
    applyStimulus(2'd1, 32'h0003_0006);
    base = pulseCount;
    applyStimulus(2'd0, 32'h1);
    waitCycles(3);
    checkOutput("rerr_pulses", pulseCount - base, 32'd0);
    readReg(2'd2, rd); checkOutput("rerr_status", rd, 32'hF08);
    applyStimulus(2'd2, 32'h8);

    // ABORT during WAIT at index 3
    applyStimulus(2'd1, 32'h0006_0001);
    base = pulseCount;
    applyStimulus(2'd0, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (act_start && act_index == 4'd3) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_reach_idx3", {31'b0, found}, 32'h1);
    @(negedge clk);
    applyStimulus(2'd0, 32'h2);
    readReg(2'd2, rd); checkOutput("abort_idle_next", rd, 32'h300);
    waitCycles(10);
    checkOutput("abort_pulses", pulseCount - base, 32'd3);
    readReg(2'd2, rd); checkOutput("abort_status", rd, 32'h300);
    respEn = 1'b0;

    // START and ABORT together
    base = pulseCount;
    applyStimulus(2'd0, 32'h3);
    checkOutput("startabort_nostart", {31'b0, act_start}, 32'h0);
    waitCycles(3);
    checkOutput("startabort_pulses", pulseCount - base, 32'd0);

    // START and RANGE writes while busy
    applyStimulus(2'd1, 32'h0008_0004);
    base = pulseCount;
    applyStimulus(2'd0, 32'h1);
    checkOutput("busy_start", {31'b0, act_start}, 32'h1);
    @(negedge clk);
    applyStimulus(2'd0, 32'h1);
    applyStimulus(2'd1, 32'h0002_0000);
    waitCycles(2);
    checkOutput("busy_pulses", pulseCount - base, 32'd1);
    readReg(2'd1, rd); checkOutput("busy_range", rd, 32'h0008_0004);
    readReg(2'd2, rd); checkOutput("busy_status", rd, 32'h401);
    applyStimulus(2'd0, 32'h2);
    readReg(2'd2, rd); checkOutput("busy_aborted", rd, 32'h400);

    // act_done during ISSUE is ignored
    applyStimulus(2'd1, 32'h0001_0000);
    base = pulseCount;
    applyStimulus(2'd0, 32'h1);
    tbDone = 1'b1;
    @(negedge clk);
    tbDone = 1'b0;
    readReg(2'd2, rd); checkOutput("issue_done_wait", rd, 32'h001);
    waitCycles(3);
    readReg(2'd2, rd); checkOutput("issue_done_held", rd, 32'h001);
    checkOutput("issue_done_pulses", pulseCount - base, 32'd1);
    tbDone = 1'b1;
    @(negedge clk);
    tbDone = 1'b0;
    checkOutput("issue_adv_start", {31'b0, act_start}, 32'h1);
    checkOutput("issue_adv_index", {28'b0, act_index}, 32'h1);
    applyStimulus(2'd0, 32'h2);
    readReg(2'd2, rd); checkOutput("issue_abort_status", rd, 32'h100);

    // act_done coincides with the timeout cycle
    applyStimulus(2'd3, 32'd4);
    base = pulseCount;
    applyStimulus(2'd0, 32'h1);
    repeat (4) @(negedge clk);
    tbDone = 1'b1;
    @(negedge clk);
    tbDone = 1'b0;
    checkOutput("race_adv_start", {31'b0, act_start}, 32'h1);
    readReg(2'd2, rd); checkOutput("race_status", rd, 32'h101);
    waitCycles(8);
    readReg(2'd2, rd); checkOutput("race_then_tmo", rd, 32'h104);
    applyStimulus(2'd2, 32'h4);

    // Manual mode
    applyStimulus(2'd0, 32'h8);
    applyStimulus(2'd1, 32'h000C_0009);
    checkOutput("man_index", {28'b0, act_index}, 32'h9);
    base = pulseCount;
    applyStimulus(2'd0, 32'h9);
    checkOutput("man_nostart", {31'b0, act_start}, 32'h0);
    waitCycles(2);
    checkOutput("man_pulses", pulseCount - base, 32'd0);
    readReg(2'd2, rd); checkOutput("man_status", rd, 32'h100);
    readReg(2'd0, rd); checkOutput("man_ctrl", rd, 32'h8);
    applyStimulus(2'd0, 32'h0);
    checkOutput("man_off_index", {28'b0, act_index}, 32'h1);

    // Reset asserted mid-run
    applyStimulus(2'd1, 32'h0003_0006);
    applyStimulus(2'd0, 32'h5);
    checkOutput("rst_irq_pre", {31'b0, irq}, 32'h1);
    applyStimulus(2'd1, 32'h0005_0002);
    applyStimulus(2'd3, 32'h0);
    applyStimulus(2'd0, 32'h5);
    checkOutput("rst_start_pre", {31'b0, act_start}, 32'h1);
    checkOutput("rst_index_pre", {28'b0, act_index}, 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_start", {31'b0, act_start}, 32'h0);
    checkOutput("rst_async_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_async_index", {28'b0, act_index}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    readReg(2'd0, rd); checkOutput("rst_ctrl", rd, 32'h0);
    readReg(2'd1, rd); checkOutput("rst_range", rd, 32'h0);
    readReg(2'd2, rd); checkOutput("rst_status", rd, 32'h0);
    readReg(2'd3, rd); checkOutput("rst_timeout", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
